muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit producing the HI/LO register pair for MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes. It sits beside the combinational ALU in the multicycle datapath. The controller FSM launches an operation with a one-cycle start pulse and stalls on `busy` until `done`. Computation is radix-2, one bit per cycle, with sign handling by magnitude conversion and post-correction.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 4).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new mul/div result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start with a mul/div op latches |a| and |b|, or raw values for unsigned ops.
  - Also latches op, the result signs and a WIDTH-bit down-counter = WIDTH.
  - Then goes to RUN.
  - start with MTHI/MTLO writes a to hi or lo at that edge. Stays IDLE; no busy, no done.
  - start with 110/111 is ignored.
- RUN, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring divide, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- RUN exit: counter decrements each cycle; at 1, go to FIX.
- FIX:
  - Signed MULT: negate the 2·WIDTH product if sign(a)≠sign(b).
  - Signed DIV: negate the quotient if sign(a)≠sign(b); give the remainder the sign of a.
  - Write hi/lo, go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. start in DONE is ignored.
- Divide by zero (b=0, DIV or DIVU): lo = all ones and hi = original a, sign correction suppressed. Still takes full latency.
- Signed overflow: DIV of 100…0 by 11…1 gives lo = 100…0, hi = 0, with no trap.
- Magnitude of the most-negative value is 2^(WIDTH-1), which is representable in the unsigned datapath.
- start in RUN/FIX is ignored. Operands are captured at start only; a/b/op may change afterwards.
- hi/lo change only in FIX (mul/div) or on an IDLE MTHI/MTLO edge.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts with no hi/lo update. Deassertion is synchronised externally.
- Let the start edge be T.
  - busy=1 from T through T+WIDTH+1, i.e. RUN for WIDTH cycles, then FIX.
  - hi/lo updated at edge T+WIDTH+1.
  - done=1 and busy=0 in the cycle after edge T+WIDTH+1.
  - Total latency: WIDTH+2 cycles from start to done; WIDTH=32 gives 34.
- A back-to-back start is accepted at the first IDLE edge after DONE. Minimum issue interval is WIDTH+3 cycles.
- MTHI/MTLO: zero-wait, hi/lo visible in the cycle after the start edge.
- busy and done are registered outputs, never combinational from start.

## Test plan
- Reset, then MULT a=0xFFFFFFFD (-3), b=5 -> done at start+34, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MULT same operands -> hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
- Boundaries:
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
  - DIV a=-5, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
- Protocol:
  - MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> both visible next cycle, done never pulses.
  - A start pulsed during RUN with changed a/b/op has no effect on the result.
- Reset asserted at cycle 10 of a DIV -> busy/done/hi/lo = 0 immediately, IDLE. A fresh MULT 6×7 afterwards gives lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Signed operations run on magnitudes and fix the result sign in FIX.
// MTHI/MTLO write HI/LO directly from IDLE with no busy cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_e             r_state;
    state_e             w_next;

    logic [WIDTH-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_res;   // quotient/product must be negated
    logic               r_neg_rem;   // remainder takes the sign of the dividend
    logic               r_dz;        // divide by zero
    logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_acc;       // product accumulator; quotient in the low half for divides
    logic [WIDTH-1:0]   r_rem;       // partial remainder

    logic               w_launch;
    logic               w_mt;
    logic               w_signed_op;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_launch    = (r_state == S_IDLE) && start && (op[2] == 1'b0);
    assign w_mt        = (r_state == S_IDLE) && start && (op[2:1] == 2'b10);
    assign w_signed_op = ~op[0];
    assign w_abs_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_abs_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add the multiplicand into the upper half when the current multiplier bit is set.
    assign w_addend = r_acc[0] ? r_opnd : '0;
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Restoring step: bring in the next dividend bit; a set bit WIDTH of the trial means it went negative.
    assign w_shift  = {r_rem, r_acc[WIDTH-1]};
    assign w_trial  = w_shift - {1'b0, r_opnd};

    // Divide by zero yields an all-ones quotient; the remainder equals |a|, so restoring the
    // dividend sign reproduces the original a exactly.
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix  = r_dz ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

    // State register with registered busy/done derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == S_RUN) || (w_next == S_FIX);
            done    <= (w_next == S_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next = S_RUN;
            S_RUN:   if (r_cnt == CNT_ONE) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_is_div  <= op[1];
                        r_neg_res <= w_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_rem <= w_signed_op && a[WIDTH-1];
                        r_dz      <= op[1] && (b == '0);
                        r_cnt     <= CNT_INIT;
                        r_rem     <= '0;
                        r_opnd    <= op[1] ? w_abs_b : w_abs_a;
                        r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                    end else if (w_mt) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else begin
                            lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_is_div) begin
                        r_rem              <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], ~w_trial[WIDTH]};
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end else begin
                        hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32) with hand-computed expected values.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Issue one operation from IDLE and wait (bounded) for done; lat = negedges from start to done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        lat = -1; bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        int lat, bc;
        run_op(3'b000, 32'hFFFFFFFD, 32'd5, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done got=%b exp=0", busy); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", lo); end
    endtask

    task automatic test_multu();
        int lat, bc;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
        run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mult_m1_hi got=%h exp=00000000", hi); end
        n_checks++; if (lo !== 32'h1) begin n_fail++; $display("FAIL mult_m1_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_div();
        int lat, bc;
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency got=%0d exp=34", lat); end
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(3'b011, 32'd7, 32'd2, lat, bc);
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got=%h exp=00000003", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_boundaries();
        int lat, bc;
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi got=%h exp=00000000", hi); end
        run_op(3'b011, 32'd100, 32'd0, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_dz_latency got=%0d exp=34", lat); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_dz_lo got=%h exp=ffffffff", lo); end
        n_checks++; if (hi !== 32'h00000064) begin n_fail++; $display("FAIL divu_dz_hi got=%h exp=00000064", hi); end
        run_op(3'b010, 32'hFFFFFFFB, 32'd0, lat, bc);
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_dz_lo got=%h exp=ffffffff", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL div_dz_hi got=%h exp=fffffffb", hi); end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 32'h12345678; b = 32'h0;
        @(negedge clk);
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done got=%b exp=0", done); end
        op = 3'b101; a = 32'h9ABCDEF0;
        @(negedge clk);
        n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=9abcdef0", lo); end
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_kept got=%h exp=12345678", hi); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mtlo_done got=%b exp=0", done); end
        op = 3'b110; a = 32'hDEADBEEF; b = 32'h3;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL noop_busy got=%b exp=0", busy); end
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL noop_hi got=%h exp=12345678", hi); end
        n_checks++; if (lo !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL noop_lo got=%h exp=9abcdef0", lo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL noop_idle got=busy%b/done%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_start_in_run();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 3'b011; a = 32'd7; b = 32'd2;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (i >= 2) begin
                op = 3'b000; a = 32'd9; b = 32'd11;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL run_start_latency got=%0d exp=34", lat); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL run_start_lo got=%h exp=00000003", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL run_start_hi got=%h exp=00000001", hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        // Still at the negedge where done is high: a start here lands on the DONE edge.
        start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_busy got=%b exp=0", busy); end
        n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL done_start_lo got=%h exp=00000003", lo); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_idle got=%b exp=0", busy); end
        run_op(3'b001, 32'd3, 32'd4, lat, bc);
        n_checks++; if (lo !== 32'd12 || hi !== 32'd0) begin
            n_fail++; $display("FAIL b2b_first got=%h_%h exp=00000000_0000000c", hi, lo);
        end
        run_op(3'b000, 32'hFFFFFFFE, 32'd3, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        n_checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL b2b_second got=%h_%h exp=ffffffff_fffffffa", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_hilo got=%h_%h exp=00000000_00000000", hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got=%b exp=0", busy); end
        run_op(3'b000, 32'd6, 32'd7, lat, bc);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL post_rst_latency got=%0d exp=34", lat); end
        n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL post_rst_lo got=%h exp=0000002a", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi got=%h exp=00000000", hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_boundaries();
        test_mthi_mtlo();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
